// File: rtl/ipsxe_floating_point_fma_special_cases_v2_0_if.sv
// Operand/result stream bundle for the FMA special-case classifier.
// master = environment (drives operands, downstream ready); slave = classifier.
interface ipsxe_floating_point_fma_special_cases_v2_0_if #(
  parameter int EXP_WIDTH = 8,
  parameter int MAN_WIDTH = 23
);
  localparam int WIDTH = 1 + EXP_WIDTH + MAN_WIDTH;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [1:0]       op;

  logic             out_valid;
  logic             out_ready;
  logic             special;
  logic [WIDTH-1:0] special_result;
  logic             c_is_0;
  logic             invalid_op;

  modport master (
    output in_valid, a, b, c, op, out_ready,
    input  in_ready, out_valid, special, special_result, c_is_0, invalid_op
  );

  modport slave (
    input  in_valid, a, b, c, op, out_ready,
    output in_ready, out_valid, special, special_result, c_is_0, invalid_op
  );
endinterface

// File: rtl/ipsxe_floating_point_fma_special_cases_v2_0.sv
// Special-value classifier for r = +/-(a*b) +/- c, running beside the mantissa
// datapath with a stall-able, bubble-carrying pipeline of PIPE_STAGES registers.
module ipsxe_floating_point_fma_special_cases_v2_0 #(
  parameter int EXP_WIDTH   = 8,
  parameter int MAN_WIDTH   = 23,
  parameter int PIPE_STAGES = 4,
  parameter int SUBNORM_EN  = 0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_aclken,
  input  logic i_flag_clr,
  ipsxe_floating_point_fma_special_cases_v2_0_if.slave bus,
  output logic o_sticky_invalid,
  output logic o_sticky_nan
);
  localparam int WIDTH = 1 + EXP_WIDTH + MAN_WIDTH;
  localparam logic [WIDTH-1:0] QNAN =
    {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(MAN_WIDTH-1){1'b0}}};
  localparam logic [WIDTH-2:0] INF_MAG = {{EXP_WIDTH{1'b1}}, {MAN_WIDTH{1'b0}}};

  typedef struct packed {
    logic zero;
    logic inf;
    logic nan;
    logic snan;
    logic sign;
  } cls_t;

  typedef struct packed {
    logic             vld;
    logic             special;
    logic [WIDTH-1:0] res;
    logic             c0;
    logic             inv;
    logic             nan;
  } stage_t;

  function automatic cls_t classify(input logic [WIDTH-1:0] x);
    cls_t                 k;
    logic [EXP_WIDTH-1:0] e;
    logic [MAN_WIDTH-1:0] m;
    logic                 man_zero;
    e        = x[WIDTH-2:MAN_WIDTH];
    m        = x[MAN_WIDTH-1:0];
    man_zero = ~|m;
    // Subnormals collapse to zero unless SUBNORM_EN treats them as finite.
    k.zero   = (~|e) & (man_zero | (SUBNORM_EN == 0));
    k.inf    = (&e) & man_zero;
    k.nan    = (&e) & ~man_zero;
    k.snan   = k.nan & ~m[MAN_WIDTH-1];
    k.sign   = x[WIDTH-1];
    return k;
  endfunction

  cls_t   ca, cb, cc;
  logic   sp, sc;
  logic   any_nan, any_snan, inf_x_zero, inf_cancel;
  logic   prod_nan, prod_inf, prod_zero, prod_fin, c_fin;
  stage_t in_stage;
  stage_t out_stage;

  always_comb begin
    ca         = classify(bus.a);
    cb         = classify(bus.b);
    cc         = classify(bus.c);
    sp         = ca.sign ^ cb.sign ^ bus.op[0];
    sc         = cc.sign ^ bus.op[1];
    any_nan    = ca.nan | cb.nan | cc.nan;
    any_snan   = ca.snan | cb.snan | cc.snan;
    inf_x_zero = (ca.inf & cb.zero) | (ca.zero & cb.inf);
    prod_nan   = ca.nan | cb.nan | inf_x_zero;
    prod_inf   = ~prod_nan & (ca.inf | cb.inf);
    prod_zero  = ~prod_nan & ~prod_inf & (ca.zero | cb.zero);
    prod_fin   = ~prod_nan & ~prod_inf & ~prod_zero;
    c_fin      = ~cc.zero & ~cc.inf & ~cc.nan;
    inf_cancel = prod_inf & cc.inf & (sp != sc);

    in_stage     = '0;
    in_stage.vld = bus.in_valid;
    in_stage.inv = any_snan | inf_x_zero | inf_cancel;
    if (any_nan | inf_x_zero | inf_cancel) begin
      in_stage.special = 1'b1;
      in_stage.res     = QNAN;
      in_stage.nan     = 1'b1;
    end else if (prod_inf) begin
      in_stage.special = 1'b1;
      in_stage.res     = {sp, INF_MAG};
    end else if (cc.inf) begin
      in_stage.special = 1'b1;
      in_stage.res     = {sc, INF_MAG};
    end else if (prod_zero & cc.zero) begin
      in_stage.special = 1'b1;
      in_stage.res     = {sp & sc, {(WIDTH-1){1'b0}}};
    end else if (prod_zero & c_fin) begin
      in_stage.special = 1'b1;
      in_stage.res     = {sc, bus.c[WIDTH-2:0]};
    end else if (cc.zero & prod_fin) begin
      in_stage.c0 = 1'b1;
    end
  end

  if (PIPE_STAGES == 0) begin : g_comb
    assign out_stage    = in_stage;
    assign bus.in_ready = i_aclken & bus.out_ready;
  end else begin : g_pipe
    stage_t pipe_q [PIPE_STAGES];
    stage_t pipe_d [PIPE_STAGES];
    logic   adv;

    // Every stage moves together, so bubbles stay where they are.
    assign adv          = i_aclken & (~out_stage.vld | bus.out_ready);
    assign bus.in_ready = adv;

    always_comb begin
      for (int i = 0; i < PIPE_STAGES; i++) pipe_d[i] = pipe_q[i];
      if (adv) begin
        pipe_d[0] = in_stage;
        for (int i = 1; i < PIPE_STAGES; i++) pipe_d[i] = pipe_q[i-1];
      end
    end

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        for (int i = 0; i < PIPE_STAGES; i++) pipe_q[i] <= '0;
      end else begin
        for (int i = 0; i < PIPE_STAGES; i++) pipe_q[i] <= pipe_d[i];
      end
    end

    assign out_stage = pipe_q[PIPE_STAGES-1];
  end

  assign bus.out_valid      = out_stage.vld;
  assign bus.special        = out_stage.vld & out_stage.special;
  assign bus.special_result = out_stage.vld ? out_stage.res : '0;
  assign bus.c_is_0         = out_stage.vld & out_stage.c0;
  assign bus.invalid_op     = out_stage.vld & out_stage.inv;

  logic deliver;
  logic sticky_invalid_d, sticky_invalid_q;
  logic sticky_nan_d, sticky_nan_q;

  assign deliver = i_aclken & out_stage.vld & bus.out_ready;

  // Clear is applied first so a same-cycle delivery still sets the flag.
  always_comb begin
    sticky_invalid_d = sticky_invalid_q;
    sticky_nan_d     = sticky_nan_q;
    if (i_aclken & i_flag_clr) begin
      sticky_invalid_d = 1'b0;
      sticky_nan_d     = 1'b0;
    end
    if (deliver & out_stage.inv) sticky_invalid_d = 1'b1;
    if (deliver & out_stage.nan) sticky_nan_d = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sticky_invalid_q <= 1'b0;
      sticky_nan_q     <= 1'b0;
    end else begin
      sticky_invalid_q <= sticky_invalid_d;
      sticky_nan_q     <= sticky_nan_d;
    end
  end

  assign o_sticky_invalid = sticky_invalid_q;
  assign o_sticky_nan     = sticky_nan_q;
endmodule
